// File: rtl/speck_round_scheduler.sv
// rtl/speck_round_scheduler.sv - sequences one SPECK round engine through all encryption rounds
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          plaintext + master key handshake (accepted only in IDLE)
//   plaintext [2n]             [n-1:0]=x, [2n-1:n]=y
//   key [4n]                   [n-1:0]=k0, then l0, l1, l2
//   out_valid/out_ready        ciphertext handshake, ciphertext held until accepted
//   ciphertext [2n]            same word order as plaintext
//   error                      sticky engine-timeout flag, cleared only by reset
//   rnd_start/rnd_subkey/rnd_text_in  drive the round engine
//   rnd_text_out/rnd_finished  returned by the round engine
//   busy                       high whenever not IDLE
module speck_round_scheduler #(
    parameter int WORD_WIDTH     = 16,
    parameter int ROUNDS         = 22,
    parameter int ALPHA          = 7,
    parameter int BETA           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*WORD_WIDTH-1:0] plaintext,
    input  logic [4*WORD_WIDTH-1:0] key,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*WORD_WIDTH-1:0] ciphertext,
    output logic                    error,
    output logic                    rnd_start,
    output logic [WORD_WIDTH-1:0]   rnd_subkey,
    output logic [2*WORD_WIDTH-1:0] rnd_text_in,
    input  logic [2*WORD_WIDTH-1:0] rnd_text_out,
    input  logic                    rnd_finished,
    output logic                    busy
);

    localparam int W  = WORD_WIDTH;
    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_RND = CW'(ROUNDS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        WAIT   = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            set_error;
    logic            fin_q;
    logic            done;
    logic [CW-1:0]   rnd_idx;
    logic [TW-1:0]   tmo_cnt;
    logic [W-1:0]    l0;
    logic [W-1:0]    l1;
    logic [W-1:0]    l2;
    logic [W-1:0]    l_new;

    function automatic logic [W-1:0] ror(input logic [W-1:0] v);
        return (v >> ALPHA) | (v << (W - ALPHA));
    endfunction

    function automatic logic [W-1:0] rol(input logic [W-1:0] v);
        return (v << BETA) | (v >> (W - BETA));
    endfunction

    // Only a rising edge of finished counts; the engine may leave the level
    // high from the previous round until it sees the next start.
    assign done  = rnd_finished & ~fin_q;

    // rnd_subkey doubles as the key-schedule k register.
    assign l_new = (rnd_subkey + ror(l0)) ^ W'(rnd_idx);

    assign in_ready  = (state == IDLE);
    assign rnd_start = (state == START);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        set_error = 1'b0;
        unique case (state)
            IDLE:   if (in_valid) state_nx = START;
            START:  state_nx = WAIT;
            WAIT: begin
                if (done) begin
                    state_nx = UPDATE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nx  = IDLE;
                    set_error = 1'b1;
                end
            end
            UPDATE: state_nx = (rnd_idx == LAST_RND) ? DONE : START;
            DONE:   if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_q       <= 1'b0;
            error       <= 1'b0;
            rnd_idx     <= '0;
            tmo_cnt     <= '0;
            rnd_subkey  <= '0;
            l0          <= '0;
            l1          <= '0;
            l2          <= '0;
            rnd_text_in <= '0;
            ciphertext  <= '0;
        end else begin
            fin_q <= rnd_finished;
            if (set_error) error <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        rnd_text_in <= plaintext;
                        rnd_subkey  <= key[W-1:0];
                        l0          <= key[2*W-1:W];
                        l1          <= key[3*W-1:2*W];
                        l2          <= key[4*W-1:3*W];
                        rnd_idx     <= '0;
                    end
                end
                START: tmo_cnt <= '0;
                WAIT:  if (!done) tmo_cnt <= tmo_cnt + TW'(1);
                UPDATE: begin
                    rnd_text_in <= rnd_text_out;
                    if (rnd_idx == LAST_RND) begin
                        ciphertext <= rnd_text_out;
                    end else begin
                        rnd_subkey <= rol(rnd_subkey) ^ l_new;
                        l0         <= l1;
                        l1         <= l2;
                        l2         <= l_new;
                        rnd_idx    <= rnd_idx + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_speck_round_scheduler.sv
// tb/tb_speck_round_scheduler.sv - randomized self-checking bench for speck_round_scheduler
module tb_speck_round_scheduler;

    localparam int W   = 16;
    localparam int R   = 22;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] plaintext = '0;
    logic [63:0] key = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ciphertext;
    logic        error;
    logic        rnd_start;
    logic [15:0] rnd_subkey;
    logic [31:0] rnd_text_in;
    logic [31:0] rnd_text_out;
    logic        rnd_finished;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    speck_round_scheduler #(
        .WORD_WIDTH(W), .ROUNDS(R), .ALPHA(7), .BETA(2), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .ciphertext(ciphertext), .error(error), .rnd_start(rnd_start),
        .rnd_subkey(rnd_subkey), .rnd_text_in(rnd_text_in), .rnd_text_out(rnd_text_out),
        .rnd_finished(rnd_finished), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ror16(input logic [15:0] v, input int r);
        return (v >> r) | (v << (16 - r));
    endfunction

    function automatic logic [15:0] rol16(input logic [15:0] v, input int r);
        return (v << r) | (v >> (16 - r));
    endfunction

    function automatic logic [31:0] round_fn(input logic [31:0] t, input logic [15:0] k);
        logic [15:0] x;
        logic [15:0] y;
        x = (ror16(t[15:0], 7) + t[31:16]) ^ k;
        y = rol16(t[31:16], 2) ^ x;
        return {y, x};
    endfunction

    // Reference: textbook SPECK with the key schedule laid out as arrays k[], l[].
    logic [15:0] exp_sk [R];

    function automatic logic [31:0] ref_encrypt(input logic [31:0] pt, input logic [63:0] k);
        logic [15:0] ls [R+2];
        logic [31:0] t;
        exp_sk[0] = k[15:0];
        ls[0] = k[31:16];
        ls[1] = k[47:32];
        ls[2] = k[63:48];
        for (int i = 0; i < R - 1; i++) begin
            ls[i+3]     = (exp_sk[i] + ror16(ls[i], 7)) ^ 16'(i);
            exp_sk[i+1] = rol16(exp_sk[i], 2) ^ ls[i+3];
        end
        t = pt;
        for (int i = 0; i < R; i++) t = round_fn(t, exp_sk[i]);
        return t;
    endfunction

    // Round engine stub: random latency, finished level held until next start.
    logic        eng_fin;
    logic        eng_act;
    int          eng_cnt;
    logic [31:0] eng_txt;
    logic [15:0] eng_k;
    logic [31:0] eng_out;
    logic        hang = 1'b0;

    assign rnd_finished = eng_fin;
    assign rnd_text_out = eng_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_fin <= 1'b0;
            eng_act <= 1'b0;
            eng_cnt <= 0;
            eng_out <= '0;
            eng_txt <= '0;
            eng_k   <= '0;
        end else if (rnd_start) begin
            eng_fin <= 1'b0;
            eng_act <= !hang;
            eng_cnt <= $urandom_range(4, 0);
            eng_txt <= rnd_text_in;
            eng_k   <= rnd_subkey;
        end else if (eng_act) begin
            if (eng_cnt == 0) begin
                eng_fin <= 1'b1;
                eng_act <= 1'b0;
                eng_out <= round_fn(eng_txt, eng_k);
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    // Subkey and start-pulse monitor.
    logic [15:0] sk_q [$];
    int          wide = 0;
    logic        prev_start = 1'b0;

    always @(negedge clk) begin
        if (rnd_start) begin
            sk_q.push_back(rnd_subkey);
            if (prev_start) wide++;
        end
        prev_start = rnd_start;
    end

    task automatic check_idle_reset(input string tag);
        check({tag, "_in_ready"},   64'(in_ready), 64'd1);
        check({tag, "_out_valid"},  64'(out_valid), 64'd0);
        check({tag, "_error"},      64'(error), 64'd0);
        check({tag, "_rnd_start"},  64'(rnd_start), 64'd0);
        check({tag, "_busy"},       64'(busy), 64'd0);
        check({tag, "_ciphertext"}, 64'(ciphertext), 64'd0);
        check({tag, "_subkey"},     64'(rnd_subkey), 64'd0);
        check({tag, "_text_in"},    64'(rnd_text_in), 64'd0);
    endtask

    // Called at a negedge. Optionally keeps in_valid high with the next
    // transaction during backpressure so the following call is back-to-back.
    task automatic send_and_check(input logic [31:0] pt, input logic [63:0] k, input int bp,
                                  input bit offer, input logic [31:0] npt, input logic [63:0] nk,
                                  output logic [31:0] ct_obs);
        logic [31:0] exp_ct;
        int t;
        exp_ct = ref_encrypt(pt, k);
        sk_q.delete();
        wide = 0;
        plaintext = pt;
        key = k;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        plaintext = $urandom;
        key = {$urandom, $urandom};
        t = 0;
        while (!out_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ct_obs = ciphertext;
        check("out_valid", 64'(out_valid), 64'd1);
        check("ciphertext", 64'(ciphertext), 64'(exp_ct));
        check("error_clear", 64'(error), 64'd0);
        check("start_count", 64'(sk_q.size()), 64'(R));
        check("start_width", 64'(wide), 64'd0);
        for (int i = 0; i < R; i++)
            if (i < sk_q.size()) check($sformatf("subkey%0d", i), 64'(sk_q[i]), 64'(exp_sk[i]));
        if (offer) begin
            plaintext = npt;
            key = nk;
            in_valid = 1'b1;
        end else begin
            in_valid = 1'b1;
        end
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_ciphertext", 64'(ciphertext), 64'(exp_ct));
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        if (!offer) in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
    endtask

    localparam logic [31:0] VEC_PT  = 32'h694c_6574;
    localparam logic [63:0] VEC_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] VEC_CT  = 32'h42f2_a868;

    logic [31:0] ct;
    logic [31:0] rpt [6];
    logic [63:0] rkey [6];

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_idle_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer vector with 20 cycles of backpressure, next tx offered meanwhile.
        for (int i = 0; i < 6; i++) begin
            rpt[i]  = $urandom;
            rkey[i] = {$urandom, $urandom};
        end
        send_and_check(VEC_PT, VEC_KEY, 20, 1'b1, rpt[0], rkey[0], ct);
        check("kat_ct", 64'(ct), 64'(VEC_CT));
        if (sk_q.size() > 0) check("kat_subkey0", 64'(sk_q[0]), 64'h0100);

        // Back-to-back random transactions with random backpressure.
        for (int i = 0; i < 6; i++)
            send_and_check(rpt[i], rkey[i], $urandom_range(5, 0), (i < 5),
                           (i < 5) ? rpt[(i < 5) ? i + 1 : i] : 32'h0,
                           (i < 5) ? rkey[(i < 5) ? i + 1 : i] : 64'h0, ct);

        // Engine never finishes: error after the START cycle plus TMO WAIT cycles.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hang = 1'b1;
        plaintext = VEC_PT;
        key = VEC_KEY;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("tmo_start_seen", 64'(rnd_start), 64'd1);
        n = 0;
        while (!error && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", 64'(n), 64'(TMO + 1));
        check("tmo_in_ready", 64'(in_ready), 64'd1);
        check("tmo_out_valid", 64'(out_valid), 64'd0);
        check("tmo_busy", 64'(busy), 64'd0);
        hang = 1'b0;
        repeat (10) @(negedge clk);
        check("tmo_sticky", 64'(error), 64'd1);
        rst_n = 1'b0;
        #1;
        check("tmo_cleared", 64'(error), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset while waiting on round 10.
        sk_q.delete();
        plaintext = rpt[2];
        key = rkey[2];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (sk_q.size() < 11 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_round_count", 64'(sk_q.size()), 64'd11);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_reset("async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_and_check(VEC_PT, VEC_KEY, 2, 1'b0, 32'h0, 64'h0, ct);
        check("post_reset_kat", 64'(ct), 64'(VEC_CT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
